sobel_window_gen: RTL and testbench
===================================

Name: sobel_window_gen

Overview:
- Streaming 3x3 window generator that sits directly upstream of the Sobel gradient wrapper.
- Accepts a raster-order 8-bit grayscale pixel stream, one pixel per accepted cycle.
- Holds the two previous image rows in line buffers.
- Presents each complete 3x3 neighbourhood as windowBuffer[0:8], with a one-cycle start_calculations strobe, for the gradient stage to consume.

Parameters:
IMG_WIDTH, 640, pixels per row (>=3)
IMG_HEIGHT, 480, rows per frame (>=3)

Ports:
clk  input  1  system clock, rising-edge
n_rst  input  1  asynchronous active-low reset
pixel_in  input  8  incoming pixel, unsigned grayscale
pixel_valid  input  1  pixel_in is accepted this cycle
frame_start  input  1  synchronous frame restart; when high, counters clear and a same-cycle valid pixel is (row 0, col 0)
windowBuffer  output  8 x [0:8]  3x3 window, row-major, [0]=top-left, [8]=bottom-right (newest pixel)
start_calculations  output  1  one-cycle strobe: windowBuffer holds a new complete window
frame_done  output  1  one-cycle strobe after the last pixel of a frame is accepted

Behaviour:
- Reset (n_rst low, async):
  - windowBuffer all 0, start_calculations 0, frame_done 0.
  - Row/col counters 0; 3x3 shift registers 0.
  - Line-buffer RAM contents are not reset.
- Counters:
  - col runs 0..IMG_WIDTH-1; row runs 0..IMG_HEIGHT-1.
  - Both advance only on an accepted pixel (pixel_valid=1).
  - col wraps to 0 and row increments at col=IMG_WIDTH-1.
  - After (IMG_HEIGHT-1, IMG_WIDTH-1), both wrap to 0 and frame_done pulses on the next cycle.
- Line buffers: two circular buffers of IMG_WIDTH x 8 bits each.
  - lb_prev holds row r-1; lb_old holds row r-2.
  - On an accepted pixel at column c, read lb_prev[c] and lb_old[c], then write lb_old[c]<=lb_prev[c] and lb_prev[c]<=pixel_in.
  - Read-before-write at the same address within one cycle.
- Window shift, per accepted pixel:
  - Each window row shifts left one column.
  - New right column: [2]<=lb_old[c], [5]<=lb_prev[c], [8]<=pixel_in.
  - Index map: [0..2] row r-2 cols c-2..c; [3..5] row r-1; [6..8] row r. Window centre is (r-1, c-1).
- Window-valid condition: accepted pixel with row>=2 and col>=2.
  - Windows never span a row boundary; left columns are stale until col=2 and are masked by this rule.
- Latency: windowBuffer and start_calculations are registered.
  - They update the cycle after the accepting edge, i.e. visible 1 clk after pixel_valid is sampled.
  - start_calculations is high exactly one cycle per valid window.
  - windowBuffer holds its value until the next valid window.
- Window count: (IMG_WIDTH-2)*(IMG_HEIGHT-2) strobes per frame.
- Stall: pixel_valid=0 means no counter, line-buffer or window change; start_calculations=0.
- frame_start handling:
  - frame_start=1 forces row=col=0 before acceptance; a coincident valid pixel is stored as (0,0).
  - Mid-frame, partial-row data is discarded logically: no strobe until (2,2) of the new frame.
  - frame_done is not asserted for the aborted frame.
- Reset mid-frame: counters restart at (0,0); stale line-buffer data is never emitted because row>=2 gating applies.
- Back-to-back frames: the pixel after frame wrap is (0,0) with no idle cycle required; the first window of the new frame appears only at its (2,2).
- Simultaneous frame_done and frame_start: frame_done still pulses for the completed frame.

Test Plan:
Convention for all scenarios: IMG_WIDTH=4, IMG_HEIGHT=4, pixel(r,c)=16r+c, continuous pixel_valid from frame_start.
- Reset: hold n_rst low during clk -> all outputs 0; releasing n_rst with no pixels -> outputs remain 0.
- Full frame: 16 pixels -> exactly 4 strobes.
  - Strobe 1 is one cycle after pixel 10 is accepted, windowBuffer={0,1,2,16,17,18,32,33,34}.
  - Strobe 4 has {17,18,19,33,34,35,49,50,51}.
  - frame_done is high the cycle after pixel 15.
- Row boundary: after pixel (2,3), pixels (3,0) and (3,1) -> no strobe. Pixel (3,2) -> window {16,17,18,32,33,34,48,49,50}.
- Stall: deassert pixel_valid for 5 cycles between (2,2) and (2,3) -> single strobe for (2,2), no strobes during stall, strobe for (2,3) one cycle after it is accepted with {1,2,3,17,18,19,33,34,35}.
- frame_start mid-frame at pixel (2,1): new frame values 100+16r+c -> first strobe only after new (2,2), window {100,101,102,116,117,118,132,133,134}; no frame_done for the aborted frame.
- Async reset asserted mid-row 2 (between clock edges), then a new frame -> outputs zero immediately; no strobe until new (2,2); 4 strobes with correct values for the new frame.

Source files
------------

// File: rtl/sobel_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : sobel_window_gen
// Purpose  : Streaming 3x3 neighbourhood generator for a Sobel gradient stage.
//            Takes a raster-order 8-bit pixel stream, keeps the two previous
//            rows in circular line buffers and emits every complete 3x3
//            window together with a one-cycle start_calculations strobe.
// Ports    : clk                - rising-edge system clock
//            n_rst              - asynchronous active-low reset
//            pixel_in[7:0]      - incoming grayscale pixel
//            pixel_valid        - pixel_in accepted this cycle
//            frame_start        - synchronous frame restart (pixel is (0,0))
//            windowBuffer[0:8]  - row-major window, [8] = newest pixel
//            start_calculations - one-cycle strobe, new window available
//            frame_done         - one-cycle strobe after a frame's last pixel
// Revision : 1.0 - initial release
// ============================================================================
module sobel_window_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] pixel_in,
  input  logic       pixel_valid,
  input  logic       frame_start,
  output logic [7:0] windowBuffer [0:8],
  output logic       start_calculations,
  output logic       frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  localparam logic [CW-1:0] c_col_last = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] c_row_last = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] c_col_two  = CW'(2);
  localparam logic [RW-1:0] c_row_two  = RW'(2);

  // Position counters
  logic [CW-1:0] col_q, col_d, col_cur;
  logic [RW-1:0] row_q, row_d, row_cur;

  // Line buffers: no reset, behave as plain RAM
  logic [7:0] lb_prev [0:IMG_WIDTH-1];
  logic [7:0] lb_old  [0:IMG_WIDTH-1];
  logic [7:0] prev_rd;
  logic [7:0] old_rd;

  // 3x3 shift registers and the registered output copy
  logic [7:0] win_q  [0:8];
  logic [7:0] win_d  [0:8];
  logic [7:0] wout_q [0:8];
  logic       strobe_q;
  logic       done_q;

  logic       accept;
  logic       last_pix;
  logic       win_valid;

  // frame_start overrides the stored position in the same cycle so that a
  // coincident valid pixel lands at (0,0).
  always_comb begin
    col_cur   = frame_start ? '0 : col_q;
    row_cur   = frame_start ? '0 : row_q;
    accept    = pixel_valid;
    prev_rd   = lb_prev[col_cur];
    old_rd    = lb_old[col_cur];
    last_pix  = (row_cur == c_row_last) && (col_cur == c_col_last);
    // Left columns carry the previous row's tail until col=2; the col gate
    // keeps those mixed windows from ever being reported.
    win_valid = accept && (row_cur >= c_row_two) && (col_cur >= c_col_two);
  end

  always_comb begin
    col_d = col_cur;
    row_d = row_cur;
    if (accept) begin
      if (col_cur == c_col_last) begin
        col_d = '0;
        row_d = (row_cur == c_row_last) ? '0 : row_cur + RW'(1);
      end else begin
        col_d = col_cur + CW'(1);
      end
    end
  end

  // Each window row moves one column left; the right column is fed from the
  // line buffers (pre-write values) and the live pixel.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      win_d[3*k]   = win_q[3*k+1];
      win_d[3*k+1] = win_q[3*k+2];
      win_d[3*k+2] = win_q[3*k+2];
    end
    win_d[2] = old_rd;
    win_d[5] = prev_rd;
    win_d[8] = pixel_in;
  end

  // Read-before-write: the reads above use the contents before this edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_old[col_cur]  <= prev_rd;
      lb_prev[col_cur] <= pixel_in;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      col_q    <= '0;
      row_q    <= '0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        win_q[i]  <= '0;
        wout_q[i] <= '0;
      end
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      strobe_q <= win_valid;
      done_q   <= accept && last_pix;
      for (int i = 0; i < 9; i++) begin
        if (accept) begin
          win_q[i] <= win_d[i];
        end
        if (win_valid) begin
          wout_q[i] <= win_d[i];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 9; i++) begin
      windowBuffer[i] = wout_q[i];
    end
    start_calculations = strobe_q;
    frame_done         = done_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_sobel_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_sobel_window_gen
// Purpose  : Self-checking bench for sobel_window_gen on a 4x4 image.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/100ps
module tb_sobel_window_gen;

  localparam int W = 4;
  localparam int H = 4;

  logic       clk;
  logic       n_rst;
  logic [7:0] pixel_in;
  logic       pixel_valid;
  logic       frame_start;
  logic [7:0] win_arr [0:8];
  logic       start_calculations;
  logic       frame_done;

  sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .pixel_in           (pixel_in),
    .pixel_valid        (pixel_valid),
    .frame_start        (frame_start),
    .windowBuffer       (win_arr),
    .start_calculations (start_calculations),
    .frame_done         (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [71:0] win;
  } exp_t;

  exp_t        sb_q [$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_strobe = 0;
  int          cyc = 0;
  int          exp_fd_cyc = -1;
  logic [71:0] last_win = '0;
  logic [7:0]  img [0:H-1][0:W-1];
  int          tr = 0;
  int          tc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [71:0] pack_win();
    logic [71:0] p;
    for (int i = 0; i < 9; i++) p[71-8*i -: 8] = win_arr[i];
    return p;
  endfunction

  // Scoreboard: pops expected windows in the exact cycle they are due.
  always @(negedge clk) begin
    exp_t        e;
    logic [71:0] got;
    logic        fd_exp;
    got = pack_win();
    if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
      e = sb_q.pop_front();
      n_cmp++;
      if (start_calculations !== 1'b1) begin
        n_err++;
        $display("FAIL strobe_missing cyc=%0d got=%b want=1", cyc, start_calculations);
      end
      n_cmp++;
      if (got !== e.win) begin
        n_err++;
        $display("FAIL window cyc=%0d got=%h want=%h", cyc, got, e.win);
      end
      last_win = e.win;
    end else begin
      n_cmp++;
      if (start_calculations !== 1'b0) begin
        n_err++;
        $display("FAIL spurious_strobe cyc=%0d got=%b want=0", cyc, start_calculations);
      end
      n_cmp++;
      if (got !== last_win) begin
        n_err++;
        $display("FAIL window_hold cyc=%0d got=%h want=%h", cyc, got, last_win);
      end
    end
    fd_exp = (cyc == exp_fd_cyc);
    n_cmp++;
    if (frame_done !== fd_exp) begin
      n_err++;
      $display("FAIL frame_done cyc=%0d got=%b want=%b", cyc, frame_done, fd_exp);
    end
    if (start_calculations === 1'b1) n_strobe++;
  end

  task automatic send_px(input bit fs, input int base);
    exp_t e;
    if (fs) begin
      tr = 0;
      tc = 0;
    end
    img[tr][tc] = 8'(base + 16*tr + tc);
    pixel_in    = img[tr][tc];
    pixel_valid = 1'b1;
    frame_start = fs;
    if (tr >= 2 && tc >= 2) begin
      e.cyc = cyc + 1;
      e.win = {img[tr-2][tc-2], img[tr-2][tc-1], img[tr-2][tc],
               img[tr-1][tc-2], img[tr-1][tc-1], img[tr-1][tc],
               img[tr][tc-2],   img[tr][tc-1],   img[tr][tc]};
      sb_q.push_back(e);
    end
    if (tr == H-1 && tc == W-1) exp_fd_cyc = cyc + 1;
    if (tc == W-1) begin
      tc = 0;
      tr = (tr == H-1) ? 0 : tr + 1;
    end else begin
      tc++;
    end
    @(posedge clk); #1;
    pixel_valid = 1'b0;
    frame_start = 1'b0;
    pixel_in    = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_drained(input int s0, input int want, input string name);
    n_cmp++;
    if (n_strobe - s0 != want) begin
      n_err++;
      $display("FAIL %s_strobe_count got=%0d want=%0d", name, n_strobe - s0, want);
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_pending got=%0d want=0", name, sb_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (pack_win() !== 72'h0 || start_calculations !== 1'b0 || frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold got=%h/%b/%b want=0/0/0", pack_win(), start_calculations, frame_done);
    end
    n_rst = 1'b1;
    idle(4);
    n_cmp++;
    if (pack_win() !== 72'h0 || start_calculations !== 1'b0 || frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release got=%h/%b/%b want=0/0/0", pack_win(), start_calculations, frame_done);
    end
  endtask

  task automatic test_full_frame();
    int s0 = n_strobe;
    for (int i = 0; i < 11; i++) send_px(i == 0, 0);
    n_cmp++;
    if (start_calculations !== 1'b1 || pack_win() !== 72'h00_01_02_10_11_12_20_21_22) begin
      n_err++;
      $display("FAIL full_first got=%b/%h want=1/000102101112202122", start_calculations, pack_win());
    end
    for (int i = 11; i < 16; i++) send_px(1'b0, 0);
    n_cmp++;
    if (frame_done !== 1'b1 || pack_win() !== 72'h11_12_13_21_22_23_31_32_33) begin
      n_err++;
      $display("FAIL full_last got=%b/%h want=1/111213212223313233", frame_done, pack_win());
    end
    idle(3);
    check_drained(s0, 4, "full");
  endtask

  task automatic test_stall();
    int s0 = n_strobe;
    for (int i = 0; i < 11; i++) send_px(i == 0, 0);
    idle(5);
    n_cmp++;
    if (n_strobe - s0 != 1) begin
      n_err++;
      $display("FAIL stall_count got=%0d want=1", n_strobe - s0);
    end
    send_px(1'b0, 0);
    n_cmp++;
    if (start_calculations !== 1'b1 || pack_win() !== 72'h01_02_03_11_12_13_21_22_23) begin
      n_err++;
      $display("FAIL stall_resume got=%b/%h want=1/010203111213212223", start_calculations, pack_win());
    end
    for (int i = 12; i < 16; i++) send_px(1'b0, 0);
    idle(3);
    check_drained(s0, 4, "stall");
  endtask

  task automatic test_frame_start_mid();
    int s0 = n_strobe;
    for (int i = 0; i < 9; i++) send_px(i == 0, 0);
    for (int i = 0; i < 11; i++) send_px(i == 0, 100);
    n_cmp++;
    if (start_calculations !== 1'b1 || pack_win() !== {8'd100, 8'd101, 8'd102, 8'd116, 8'd117, 8'd118, 8'd132, 8'd133, 8'd134}) begin
      n_err++;
      $display("FAIL restart_first got=%b/%h want=1/646566747576848586", start_calculations, pack_win());
    end
    for (int i = 11; i < 16; i++) send_px(1'b0, 100);
    idle(3);
    check_drained(s0, 4, "restart");
  endtask

  task automatic test_back_to_back();
    int s0 = n_strobe;
    for (int i = 0; i < 16; i++) send_px(i == 0, 0);
    for (int i = 0; i < 16; i++) send_px(1'b0, 20);
    n_cmp++;
    if (frame_done !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_done got=%b want=1", frame_done);
    end
    for (int i = 0; i < 16; i++) send_px(i == 0, 40);
    idle(3);
    check_drained(s0, 12, "b2b");
  endtask

  task automatic test_async_reset();
    int s0;
    for (int i = 0; i < 11; i++) send_px(i == 0, 0);
    @(negedge clk); #1;
    n_rst = 1'b0;
    sb_q.delete();
    last_win   = '0;
    exp_fd_cyc = -1;
    tr = 0;
    tc = 0;
    #1;
    n_cmp++;
    if (pack_win() !== 72'h0 || start_calculations !== 1'b0 || frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset got=%h/%b/%b want=0/0/0", pack_win(), start_calculations, frame_done);
    end
    @(posedge clk); #1;
    n_rst = 1'b1;
    idle(1);
    s0 = n_strobe;
    for (int i = 0; i < 16; i++) send_px(1'b0, 50);
    idle(3);
    check_drained(s0, 4, "post_reset");
  endtask

  initial begin
    n_rst       = 1'b0;
    pixel_in    = '0;
    pixel_valid = 1'b0;
    frame_start = 1'b0;
    test_reset();
    test_full_frame();
    test_stall();
    test_frame_start_mid();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
